btn_loader: RTL
===============

# btn_loader

Input-side conditioner for the hex counter display path. It takes a raw load push-button, a raw count-direction switch and raw 4-bit data switches from the board. It produces clean, clock-domain-safe control for the counter: a single-cycle `carga` pulse with matching latched `data_out`, and a debounced `decrese` level. It sits between the board pins and the counter's `carga`/`data_in`/`decrese` inputs, on the main 50 MHz clock (not the divided 1 Hz clock).

## Interface
- `N`, 4: width of data switches / `data_out`.
- `DEB_CYCLES`, 500000: debounce window in `clk` cycles (10 ms at 50 MHz). Must be ≥ 2. Counter width is `$clog2(DEB_CYCLES)`.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_load`  in  1  raw load push-button, active-high, asynchronous and bouncy.
- `sw_dir`  in  1  raw direction switch, asynchronous and bouncy.
- `sw_data`  in  N  raw data switches, asynchronous.
- `carga`  out  1  one-cycle load strobe per debounced press.
- `data_out`  out  N  switch value captured with `carga`; holds until the next press.
- `decrese`  out  1  debounced direction level.
- `held`  out  1  high while the button is considered pressed (`HELD` or `RELEASING`).

## Operation
- All raw inputs (`btn_load`, `sw_dir`, every `sw_data` bit) pass through 2-flop synchronizers. Only the synchronized values (`btn_s`, `dir_s`, `data_s`) are used downstream.
- Load FSM, states `IDLE`, `ARMING`, `HELD`, `RELEASING`, with a shared counter `cnt`:
  - `IDLE`: `btn_s`=1 → `ARMING`, `cnt`←0.
  - `ARMING`: `btn_s`=0 → `IDLE` (bounce rejected, no pulse). If `btn_s`=1 and `cnt`==DEB_CYCLES-1 → `HELD`, with `carga`←1 for one cycle and `data_out`←`data_s`. Otherwise `cnt`++.
  - `HELD`: `btn_s`=0 → `RELEASING`, `cnt`←0.
  - `RELEASING`: `btn_s`=1 → `HELD`, no new pulse. If `btn_s`=0 and `cnt`==DEB_CYCLES-1 → `IDLE`. Otherwise `cnt`++.
- Exactly one `carga` pulse per accepted press, however long the button is held. Release bounce never produces a second pulse.
- Direction debounce is independent of the load FSM and uses its own counter `dcnt`:
  - If `dir_s`==`decrese`, `dcnt`←0.
  - Otherwise `dcnt`++. When `dcnt`==DEB_CYCLES-1, `decrese`←`dir_s` and `dcnt`←0.
- `cnt` and `dcnt` never exceed DEB_CYCLES-1, so no wrap-around is possible.
- `held` = (state==`HELD`) or (state==`RELEASING`), registered/decoded from state.
- Reset (`rst`=0, async, may occur at any time including mid-press):
  - state←`IDLE`, `cnt`=`dcnt`=0, all sync flops 0.
  - `carga`=0, `data_out`=0, `decrese`=0, `held`=0.
  - A press in progress at reset is discarded. After reset release, the button must go through a full `ARMING` window again before `carga` is issued.

## Timing
- All outputs are registered. No combinational path from any raw input to any output.
- Press latency: if `btn_load` is first sampled high at edge 1 and stays high, `ARMING` is entered at edge 3 and `carga` is high for exactly the cycle following edge DEB_CYCLES+3.
- `data_out` changes on the same edge `carga` rises. It reflects `data_s`, i.e. the switch value two cycles earlier.
- Direction latency: a stable change on `sw_dir` sampled at edge 1 appears on `decrese` after edge DEB_CYCLES+2.
- Release-to-rearm: the button must read 0 for DEB_CYCLES consecutive cycles in `RELEASING` before `IDLE` is reached. A new press can then be accepted.
- `data_s` is not required to be stable across bits (switches are operator-static). No handshake with the counter; the counter samples `carga` on the 50 MHz domain.

## Test plan
All scenarios use DEB_CYCLES=4, N=4.
- Reset: hold `rst`=0 with all raw inputs toggling → `carga`=0, `data_out`=0, `decrese`=0 and `held`=0 throughout. Release `rst` → outputs stay 0 until stimulus.
- Clean press: `sw_data`=4'hA, raw `btn_load` 0→1 at edge 1 and held 20 cycles → single `carga` pulse after edge 7, `data_out`=4'hA from that edge, `held`=1. Release → `held`=0 after RELEASING completes, with no second pulse.
- Bounce rejection: `btn_load` toggles 1,0,1,0 with each high lasting 2 cycles (< DEB_CYCLES), then goes low → no `carga`, `data_out` unchanged, state returns to `IDLE`.
- Release bounce: from `HELD`, `btn_load` goes 0 for 2 cycles, 1 for 1 cycle, then 0 → no extra `carga`. Next clean press with `sw_data`=4'h3 → exactly one pulse, `data_out`=4'h3.
- Direction: `sw_dir` 0→1 stable → `decrese`=1 after edge 6. A 2-cycle glitch of `sw_dir` to 0 → `decrese` stays 1.
- Reset mid-operation: assert `rst` while in `ARMING` with `cnt`=2 → no pulse. After release, with the button held continuously, `carga` appears DEB_CYCLES+3 edges after the first post-reset sample.

Source files
------------

// File: rtl/btn_loader.sv
// Board-pin conditioner for the hex counter: synchronizes raw switches and button,
// debounces them and emits a single-cycle load strobe with the captured data.
module btn_loader #(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_load,
  input  logic         sw_dir,
  input  logic [N-1:0] sw_data,
  output logic         carga,
  output logic [N-1:0] data_out,
  output logic         decrese,
  output logic         held,
  output logic [1:0]   state_dbg
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] dcnt;

  logic          btn_meta, btn_s;
  logic          dir_meta, dir_s;
  logic [N-1:0]  data_meta, data_s;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta  <= 1'b0;
      btn_s     <= 1'b0;
      dir_meta  <= 1'b0;
      dir_s     <= 1'b0;
      data_meta <= '0;
      data_s    <= '0;
    end else begin
      btn_meta  <= btn_load;
      btn_s     <= btn_meta;
      dir_meta  <= sw_dir;
      dir_s     <= dir_meta;
      data_meta <= sw_data;
      data_s    <= data_meta;
    end
  end

  // Load FSM: one strobe per accepted press; a high seen while releasing
  // returns to HELD without re-issuing the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      carga    <= 1'b0;
      data_out <= '0;
      held     <= 1'b0;
    end else begin
      carga <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= ARMING;
            cnt   <= '0;
          end
        end
        ARMING: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            state    <= HELD;
            carga    <= 1'b1;
            data_out <= data_s;
            held     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASING;
            cnt   <= '0;
          end
        end
        RELEASING: begin
          if (btn_s) begin
            state <= HELD;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
            held  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

  // Direction level only follows dir_s after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      decrese <= 1'b0;
      dcnt    <= '0;
    end else if (dir_s == decrese) begin
      dcnt <= '0;
    end else if (dcnt == CNT_MAX) begin
      decrese <= dir_s;
      dcnt    <= '0;
    end else begin
      dcnt <= dcnt + CW'(1);
    end
  end

endmodule
